// File: rtl/branch_redirect_unit_if.sv
// Instruction-memory fetch bus: req/ack handshake with a held address.
// The redirect unit is the master; the instruction memory is the slave.
interface branch_redirect_unit_if;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;

    modport master (
        output imem_req,
        output imem_addr,
        input  imem_ack
    );

    modport slave (
        input  imem_req,
        input  imem_addr,
        output imem_ack
    );
endinterface

// File: rtl/branch_redirect_unit.sv
// Fetch-PC owner: sequential fetch over imem, redirect/flush on taken branches and jumps, annul
// on not-taken likely branches. Define BRANCH_STATS_EN to build saturating branch counters.
module branch_redirect_unit #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int unsigned STATS_W  = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    branch_redirect_unit_if.master imem_bus,
    input  logic                   stall,
    input  logic                   br_valid,
    input  logic [3:0]             br_func,
    input  logic                   br_taken,
    input  logic [31:0]            br_pc,
    input  logic [15:0]            br_offset,
    input  logic                   jmp_valid,
    input  logic [25:0]            jmp_index,
    output logic [31:0]            pc,
    output logic                   pc_valid,
    output logic                   flush,
    output logic                   annul,
    output logic [STATS_W-1:0]     stat_branches,
    output logic [STATS_W-1:0]     stat_taken
);

    typedef enum logic [1:0] {StIdle, StFetch, StDrain, StRedirect} state_e;

    state_e      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] target_q, target_d;
    logic [31:0] pc_q, pc_d;
    logic        pc_valid_q, pc_valid_d;
    logic        flush_q, annul_q;

    logic        br_legal, br_event, redirect, annul_event;
    logic [31:0] pc_plus4, br_target, jmp_target, target;

    // A simultaneous jump masks the branch completely (no redirect, annul or count from it).
    assign br_legal    = (br_func == 4'b0010) || (br_func == 4'b0011) || br_func[3];
    assign br_event    = br_valid && br_legal && !jmp_valid;
    assign redirect    = jmp_valid || (br_event && br_taken);
    assign annul_event = br_event && !br_taken && br_func[3] && br_func[0];

    assign pc_plus4   = br_pc + 32'd4;
    assign br_target  = pc_plus4 + {{14{br_offset[15]}}, br_offset, 2'b00};
    assign jmp_target = {pc_plus4[31:28], jmp_index, 2'b00};
    assign target     = jmp_valid ? jmp_target : br_target;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        target_d   = target_q;
        pc_d       = pc_q;
        pc_valid_d = 1'b0;
        unique case (state_q)
            StIdle, StRedirect: begin
                if (redirect) begin
                    addr_d  = target;
                    state_d = StRedirect;
                end else if (!stall) begin
                    state_d = StFetch;
                end else begin
                    state_d = StIdle;
                end
            end
            StFetch: begin
                if (redirect) begin
                    // An ack in the redirect cycle belongs to the squashed path and is dropped.
                    if (imem_bus.imem_ack) begin
                        addr_d  = target;
                        state_d = StRedirect;
                    end else begin
                        target_d = target;
                        state_d  = StDrain;
                    end
                end else if (imem_bus.imem_ack) begin
                    pc_d       = addr_q;
                    pc_valid_d = 1'b1;
                    addr_d     = addr_q + 32'd4;
                    state_d    = stall ? StIdle : StFetch;
                end
            end
            StDrain: begin
                if (imem_bus.imem_ack) begin
                    addr_d  = redirect ? target : target_q;
                    state_d = StRedirect;
                end else if (redirect) begin
                    target_d = target;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            addr_q     <= RESET_PC;
            target_q   <= RESET_PC;
            pc_q       <= RESET_PC;
            pc_valid_q <= 1'b0;
            flush_q    <= 1'b0;
            annul_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            target_q   <= target_d;
            pc_q       <= pc_d;
            pc_valid_q <= pc_valid_d;
            flush_q    <= redirect;
            annul_q    <= annul_event;
        end
    end

    assign imem_bus.imem_req  = (state_q == StFetch) || (state_q == StDrain);
    assign imem_bus.imem_addr = addr_q;
    assign pc                 = pc_q;
    assign pc_valid           = pc_valid_q;
    assign flush              = flush_q;
    assign annul              = annul_q;

`ifdef BRANCH_STATS_EN
    logic [STATS_W-1:0] br_cnt_q, taken_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            if (br_event && !(&br_cnt_q)) begin
                br_cnt_q <= br_cnt_q + STATS_W'(1);
            end
            if (br_event && br_taken && !(&taken_cnt_q)) begin
                taken_cnt_q <= taken_cnt_q + STATS_W'(1);
            end
        end
    end

    assign stat_branches = br_cnt_q;
    assign stat_taken    = taken_cnt_q;
`else
    assign stat_branches = '0;
    assign stat_taken    = '0;
`endif

endmodule

// File: tb/tb_branch_redirect_unit.sv
// Scoreboard bench for branch_redirect_unit: stimulus pushes expected fetch addresses, pcs and
// flush/annul cycles; an imem responder and an output monitor pop and compare.
module tb_branch_redirect_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        stall = 1'b1;
    logic        br_valid = 1'b0;
    logic [3:0]  br_func = 4'd0;
    logic        br_taken = 1'b0;
    logic [31:0] br_pc = 32'd0;
    logic [15:0] br_offset = 16'd0;
    logic        jmp_valid = 1'b0;
    logic [25:0] jmp_index = 26'd0;
    logic [31:0] pc;
    logic        pc_valid, flush, annul;
    logic [15:0] stat_branches, stat_taken;
    logic        resp_ack = 1'b0;
    logic        force_ack = 1'b0;

    int          n_checks = 0;
    int          n_fail = 0;
    int          cyc = 0;
    int          ack_delay = 0;
    int          ack_cnt = 0;
    logic [31:0] exp_req[$];
    logic [31:0] exp_pc[$];
    int          exp_flush[$];
    int          exp_annul[$];

    always #5 clk = ~clk;

    branch_redirect_unit_if bus ();
    assign bus.imem_ack = resp_ack | force_ack;

    branch_redirect_unit dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .imem_bus      (bus),
        .stall         (stall),
        .br_valid      (br_valid),
        .br_func       (br_func),
        .br_taken      (br_taken),
        .br_pc         (br_pc),
        .br_offset     (br_offset),
        .jmp_valid     (jmp_valid),
        .jmp_index     (jmp_index),
        .pc            (pc),
        .pc_valid      (pc_valid),
        .flush         (flush),
        .annul         (annul),
        .stat_branches (stat_branches),
        .stat_taken    (stat_taken)
    );

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // imem model: acks only addresses the scoreboard expects, after ack_delay waiting cycles.
    always @(negedge clk) begin
        if (!rst_n) begin
            resp_ack <= 1'b0;
            ack_cnt  <= 0;
        end else if (bus.imem_req && exp_req.size() > 0) begin
            if (ack_cnt >= ack_delay) begin
                check32("imem_addr", bus.imem_addr, exp_req.pop_front());
                resp_ack <= 1'b1;
                ack_cnt  <= 0;
            end else begin
                resp_ack <= 1'b0;
                ack_cnt  <= ack_cnt + 1;
            end
        end else begin
            resp_ack <= 1'b0;
            ack_cnt  <= 0;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            if (pc_valid) begin
                if (exp_pc.size() == 0) check32("pc_valid_spurious", {31'd0, pc_valid}, 32'd0);
                else check32("pc", pc, exp_pc.pop_front());
            end
            if (flush) begin
                if (exp_flush.size() == 0) check32("flush_spurious", {31'd0, flush}, 32'd0);
                else check32("flush_cycle", cyc, exp_flush.pop_front());
            end else if (exp_flush.size() > 0 && exp_flush[0] <= cyc) begin
                check32("flush_missing", {31'd0, flush}, 32'd1);
                void'(exp_flush.pop_front());
            end
            if (annul) begin
                if (exp_annul.size() == 0) check32("annul_spurious", {31'd0, annul}, 32'd0);
                else check32("annul_cycle", cyc, exp_annul.pop_front());
            end else if (exp_annul.size() > 0 && exp_annul[0] <= cyc) begin
                check32("annul_missing", {31'd0, annul}, 32'd1);
                void'(exp_annul.pop_front());
            end
        end
    end

    task automatic do_reset();
        @(negedge clk);
        rst_n     = 1'b0;
        stall     = 1'b1;
        br_valid  = 1'b0;
        jmp_valid = 1'b0;
        force_ack = 1'b0;
        repeat (2) @(negedge clk);
        check32("rst_imem_req", {31'd0, bus.imem_req}, 32'd0);
        check32("rst_imem_addr", bus.imem_addr, 32'h0);
        check32("rst_pc", pc, 32'h0);
        check32("rst_outputs", {29'd0, pc_valid, flush, annul}, 32'd0);
        check32("rst_stats", {stat_branches, stat_taken}, 32'd0);
        exp_req.delete();
        exp_pc.delete();
        exp_flush.delete();
        exp_annul.delete();
        #2 rst_n = 1'b1;
    endtask

    // One-cycle branch/jump pulse; expected flush/annul land one cycle after the drive cycle.
    task automatic issue(input logic bv, input logic [3:0] f, input logic t,
                         input logic [31:0] bpc, input logic [15:0] off,
                         input logic jv, input logic [25:0] ji,
                         input logic exp_fl, input logic exp_an);
        @(posedge clk);
        #1;
        br_valid  = bv;
        br_func   = f;
        br_taken  = t;
        br_pc     = bpc;
        br_offset = off;
        jmp_valid = jv;
        jmp_index = ji;
        if (exp_fl) exp_flush.push_back(cyc + 1);
        if (exp_an) exp_annul.push_back(cyc + 1);
        @(posedge clk);
        #1;
        br_valid  = 1'b0;
        jmp_valid = 1'b0;
    endtask

    task automatic wait_quiet(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (exp_req.size() + exp_pc.size() + exp_flush.size() + exp_annul.size() == 0) break;
        end
        check32("scoreboard_timeout",
                exp_req.size() + exp_pc.size() + exp_flush.size() + exp_annul.size(), 32'd0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #(10 * 90000);
        $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        do_reset();

        // Sequential fetch, ack every second cycle.
        ack_delay = 1;
        exp_req.push_back(32'h0); exp_req.push_back(32'h4); exp_req.push_back(32'h8);
        exp_pc.push_back(32'h0);  exp_pc.push_back(32'h4);  exp_pc.push_back(32'h8);
        stall = 1'b0;
        wait_quiet(40);

        // Reset mid-fetch, then a stray ack in IDLE must be ignored.
        do_reset();
        @(posedge clk); #1 force_ack = 1'b1;
        @(posedge clk); #1 force_ack = 1'b0;
        repeat (2) @(negedge clk);
        check32("stray_ack_req", {31'd0, bus.imem_req}, 32'd0);
        check32("stray_ack_addr", bus.imem_addr, 32'h0);

        // Taken beq from IDLE: 0x100 + 4 - 8 = 0xFC.
        ack_delay = 0;
        issue(1'b1, 4'b1000, 1'b1, 32'h100, 16'hFFFE, 1'b0, 26'd0, 1'b1, 1'b0);
        check32("redirect_bubble_req", {31'd0, bus.imem_req}, 32'd0);
        check32("redirect_addr", bus.imem_addr, 32'h0FC);
        exp_req.push_back(32'h0FC);
        exp_pc.push_back(32'h0FC);
        stall = 1'b0;
        wait_quiet(40);

        // Redirect with a fetch outstanding: DRAIN, drop the 0x10 ack, fetch 0x200.
        do_reset();
        ack_delay = 0;
        for (int i = 0; i < 4; i++) begin
            exp_req.push_back(32'(4 * i));
            exp_pc.push_back(32'(4 * i));
        end
        stall = 1'b0;
        wait_quiet(40);
        issue(1'b1, 4'b1010, 1'b1, 32'h100, 16'h003F, 1'b0, 26'd0, 1'b1, 1'b0);
        check32("drain_hold_req", {31'd0, bus.imem_req}, 32'd1);
        check32("drain_hold_addr", bus.imem_addr, 32'h10);
        ack_delay = 2;
        exp_req.push_back(32'h10); exp_req.push_back(32'h200);
        exp_pc.push_back(32'h200);
        wait_quiet(40);

        // Jump and beql together: jump wins, no annul; target 0x1000_0100.
        issue(1'b1, 4'b1001, 1'b0, 32'h1000_0000, 16'h0, 1'b1, 26'h40, 1'b1, 1'b0);
        check32("jump_drain_addr", bus.imem_addr, 32'h204);
        exp_req.push_back(32'h204); exp_req.push_back(32'h1000_0100);
        exp_pc.push_back(32'h1000_0100);
        wait_quiet(40);

        // Two redirects during DRAIN: the second target (0x408) wins.
        issue(1'b1, 4'b1000, 1'b1, 32'h300, 16'h0, 1'b0, 26'd0, 1'b1, 1'b0);
        issue(1'b1, 4'b1110, 1'b1, 32'h400, 16'h1, 1'b0, 26'd0, 1'b1, 1'b0);
        exp_req.push_back(32'h1000_0104); exp_req.push_back(32'h408);
        exp_pc.push_back(32'h408);
        wait_quiet(40);

        // Annul / no-op / illegal encodings from IDLE with stall held.
        do_reset();
        issue(1'b1, 4'b1011, 1'b0, 32'h0, 16'h0, 1'b0, 26'd0, 1'b0, 1'b1);
        issue(1'b1, 4'b1010, 1'b0, 32'h0, 16'h0, 1'b0, 26'd0, 1'b0, 1'b0);
        issue(1'b1, 4'b1000, 1'b1, 32'h100, 16'h0, 1'b0, 26'd0, 1'b1, 1'b0);
        issue(1'b1, 4'b0010, 1'b1, 32'h0, 16'h0, 1'b0, 26'd0, 1'b1, 1'b0);
        issue(1'b1, 4'b0101, 1'b1, 32'h0, 16'h0, 1'b0, 26'd0, 1'b0, 1'b0);
        issue(1'b1, 4'b0011, 1'b0, 32'h0, 16'h0, 1'b0, 26'd0, 1'b0, 1'b0);
        wait_quiet(20);
`ifdef BRANCH_STATS_EN
        check32("stat_branches", {16'd0, stat_branches}, 32'd5);
        check32("stat_taken", {16'd0, stat_taken}, 32'd2);
        // 65540 more not-taken bltz resolutions push the branch counter into saturation.
        @(posedge clk); #1;
        br_valid = 1'b1; br_func = 4'b0010; br_taken = 1'b0;
        repeat (65540) @(posedge clk);
        #1 br_valid = 1'b0;
        @(negedge clk);
        check32("stat_branches_sat", {16'd0, stat_branches}, 32'h0000_FFFF);
        check32("stat_taken_hold", {16'd0, stat_taken}, 32'd2);
`else
        check32("stat_branches_off", {16'd0, stat_branches}, 32'd0);
        check32("stat_taken_off", {16'd0, stat_taken}, 32'd0);
`endif
        check32("final_scoreboard",
                exp_req.size() + exp_pc.size() + exp_flush.size() + exp_annul.size(), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
